ocp_slave_mem: RTL and testbench

OCP 2.2 slave responder backed by a small internal word memory. It is the other end of the bridge's OCP master controller. It accepts read and write requests, including INCR and STRM bursts with a data handshake, and returns SResp/SData/SRespLast. It is used as the bench target for the bridge and as a register/scratch store on the OCP side.

---
 rtl/ocp_slave_mem.sv | 159 +++++++++++++++
 tb/tb_ocp_slave_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_mem.sv
// OCP slave responder over an internal word memory: single and INCR/STRM burst reads and
// writes, optional write responses, ERR responses for out-of-range beats and unsupported commands.
module ocp_slave_mem #(
  parameter int unsigned ADDR_WDTH    = 32,
  parameter int unsigned DATA_WDTH    = 32,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned BL_WDTH      = 10,
  parameter int unsigned WRITERESP_EN = 0
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [2:0]             MCmd,
  input  logic [ADDR_WDTH-1:0]   MAddr,
  input  logic [BL_WDTH-1:0]     MBurstLength,
  input  logic [2:0]             MBurstSeq,
  input  logic [DATA_WDTH/8-1:0] MByteEn,
  input  logic [DATA_WDTH-1:0]   MData,
  input  logic                   MDataValid,
  input  logic                   MRespAccept,
  output logic                   SCmdAccept,
  output logic                   SDataAccept,
  output logic [1:0]             SResp,
  output logic [DATA_WDTH-1:0]   SData,
  output logic                   SRespLast
);

  localparam int unsigned NumBytes = DATA_WDTH / 8;
  localparam int unsigned ByteW    = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);

  localparam logic [2:0] CmdIdle = 3'b000;
  localparam logic [2:0] CmdWr   = 3'b001;
  localparam logic [2:0] CmdRd   = 3'b010;
  localparam logic [2:0] SeqStrm = 3'b101;
  localparam logic [1:0] RespNull = 2'b00;
  localparam logic [1:0] RespDva  = 2'b01;
  localparam logic [1:0] RespErr  = 2'b11;

  typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdResp, StErrResp} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WDTH-1:0]   addr_q, addr_d;
  logic [BL_WDTH-1:0]     len_q, len_d;
  logic [BL_WDTH-1:0]     cnt_q, cnt_d;
  logic                   strm_q, strm_d;
  logic                   err_q, err_d;

  logic [DATA_WDTH-1:0]   mem_q [MEM_DEPTH];

  logic [IdxW-1:0]        widx;
  logic                   oor;
  logic                   last_beat;
  logic [ADDR_WDTH-1:0]   addr_nxt;
  logic                   mem_we;

  logic                   cmd_acc, data_acc, resp_last;
  logic [1:0]             resp;
  logic [DATA_WDTH-1:0]   rdata;

  assign widx      = addr_q[ByteW +: IdxW];
  assign oor       = (addr_q >> (ByteW + IdxW)) != '0;
  assign last_beat = (cnt_q == len_q - BL_WDTH'(1));
  assign addr_nxt  = strm_q ? addr_q : addr_q + ADDR_WDTH'(NumBytes);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    strm_d    = strm_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    cmd_acc   = 1'b0;
    data_acc  = 1'b0;
    resp      = RespNull;
    rdata     = '0;
    resp_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_acc = 1'b1;
        if (MCmd != CmdIdle) begin
          addr_d = MAddr;
          len_d  = (MBurstLength == '0) ? BL_WDTH'(1) : MBurstLength;
          cnt_d  = '0;
          strm_d = (MBurstSeq == SeqStrm);
          err_d  = 1'b0;
          if (MCmd == CmdWr)      state_d = StWrData;
          else if (MCmd == CmdRd) state_d = StRdResp;
          else                    state_d = StErrResp;
        end
      end
      StWrData: begin
        data_acc = 1'b1;
        if (MDataValid) begin
          mem_we = !oor;
          if (oor) err_d = 1'b1;
          cnt_d  = cnt_q + BL_WDTH'(1);
          addr_d = addr_nxt;
          if (last_beat) state_d = (WRITERESP_EN != 0) ? StWrResp : StIdle;
        end
      end
      StWrResp: begin
        resp      = err_q ? RespErr : RespDva;
        resp_last = 1'b1;
        if (MRespAccept) state_d = StIdle;
      end
      StRdResp: begin
        resp      = oor ? RespErr : RespDva;
        rdata     = oor ? '0 : mem_q[widx];
        resp_last = last_beat;
        if (MRespAccept) begin
          cnt_d  = cnt_q + BL_WDTH'(1);
          addr_d = addr_nxt;
          if (last_beat) state_d = StIdle;
        end
      end
      StErrResp: begin
        resp      = RespErr;
        resp_last = 1'b1;
        if (MRespAccept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      strm_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      strm_q  <= strm_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset; only the write strobe is gated.
  always_ff @(posedge sys_clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (MByteEn[b]) mem_q[widx][8*b +: 8] <= MData[8*b +: 8];
      end
    end
  end

  assign SCmdAccept  = cmd_acc & ~reset;
  assign SDataAccept = data_acc & ~reset;
  assign SResp       = reset ? RespNull : resp;
  assign SData       = reset ? '0 : rdata;
  assign SRespLast   = resp_last & ~reset;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed bench: a posted-write and a responded-write instance share one stimulus stream.
module tb_ocp_slave_mem;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [2:0]  MCmd;
  logic [31:0] MAddr;
  logic [9:0]  MBurstLength;
  logic [2:0]  MBurstSeq;
  logic [3:0]  MByteEn;
  logic [31:0] MData;
  logic        MDataValid;
  logic        MRespAccept;

  logic        cacc0, dacc0, last0, cacc1, dacc1, last1;
  logic [1:0]  resp0, resp1;
  logic [31:0] sdata0, sdata1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wd  [4];
  logic [3:0]  wbe [4];
  logic [31:0] rexp [4];
  logic [1:0]  rresp [4];

  always #5 sys_clk = ~sys_clk;

  ocp_slave_mem #(.WRITERESP_EN(0)) u_dut_posted (
    .sys_clk(sys_clk), .reset(reset), .MCmd(MCmd), .MAddr(MAddr),
    .MBurstLength(MBurstLength), .MBurstSeq(MBurstSeq), .MByteEn(MByteEn), .MData(MData),
    .MDataValid(MDataValid), .MRespAccept(MRespAccept), .SCmdAccept(cacc0),
    .SDataAccept(dacc0), .SResp(resp0), .SData(sdata0), .SRespLast(last0)
  );

  ocp_slave_mem #(.WRITERESP_EN(1)) u_dut_resp (
    .sys_clk(sys_clk), .reset(reset), .MCmd(MCmd), .MAddr(MAddr),
    .MBurstLength(MBurstLength), .MBurstSeq(MBurstSeq), .MByteEn(MByteEn), .MData(MData),
    .MDataValid(MDataValid), .MRespAccept(MRespAccept), .SCmdAccept(cacc1),
    .SDataAccept(dacc1), .SResp(resp1), .SData(sdata1), .SRespLast(last1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [2:0] seq,
                          input logic [1:0] exp_wresp, input string tag);
    MCmd = 3'b001; MAddr = addr; MBurstLength = 10'(len); MBurstSeq = seq;
    #1;
    check_eq({tag, "_cmdacc"}, 32'(cacc0), 32'd1);
    tick();
    MCmd = 3'b000;
    for (int i = 0; i < len; i++) begin
      MDataValid = 1'b1; MData = wd[i]; MByteEn = wbe[i];
      #1;
      check_eq({tag, "_dacc"}, 32'(dacc0), 32'd1);
      tick();
    end
    MDataValid = 1'b0;
    #1;
    check_eq({tag, "_posted_noresp"}, 32'(resp0), 32'd0);
    check_eq({tag, "_posted_idle"}, 32'(cacc0), 32'd1);
    check_eq({tag, "_wresp"}, 32'(resp1), 32'(exp_wresp));
    check_eq({tag, "_wresp_last"}, 32'(last1), 32'd1);
    tick();
    check_eq({tag, "_wresp_held"}, 32'(resp1), 32'(exp_wresp));
    check_eq({tag, "_wresp_nocmd"}, 32'(cacc1), 32'd0);
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
    #1;
    check_eq({tag, "_wresp_done"}, 32'(resp1), 32'd0);
    check_eq({tag, "_wresp_idle"}, 32'(cacc1), 32'd1);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [2:0] seq,
                          input bit stall, input string tag);
    int nb;
    nb = (len == 0) ? 1 : len;
    MCmd = 3'b010; MAddr = addr; MBurstLength = 10'(len); MBurstSeq = seq;
    #1;
    tick();
    MCmd = 3'b000;
    for (int i = 0; i < nb; i++) begin
      if (stall) begin
        MRespAccept = 1'b0;
        #1;
        check_eq({tag, "_stall_resp"}, 32'(resp0), 32'(rresp[i]));
        check_eq({tag, "_stall_data"}, sdata0, rexp[i]);
        check_eq({tag, "_stall_last"}, 32'(last0), 32'(i == nb - 1));
        tick();
      end
      MRespAccept = 1'b1;
      #1;
      check_eq({tag, "_resp"}, 32'(resp0), 32'(rresp[i]));
      check_eq({tag, "_data"}, sdata0, rexp[i]);
      check_eq({tag, "_last"}, 32'(last0), 32'(i == nb - 1));
      tick();
    end
    MRespAccept = 1'b0;
    #1;
    check_eq({tag, "_end_noresp"}, 32'(resp0), 32'd0);
    check_eq({tag, "_end_idle"}, 32'(cacc0), 32'd1);
  endtask

  initial begin
    reset = 1'b1; MCmd = '0; MAddr = '0; MBurstLength = '0; MBurstSeq = '0;
    MByteEn = '0; MData = '0; MDataValid = 1'b0; MRespAccept = 1'b0;
    tick();
    MCmd = 3'b010;
    #1;
    check_eq("rst_cmdacc", 32'(cacc0), 32'd0);
    check_eq("rst_resp", 32'(resp1), 32'd0);
    tick();
    MCmd = 3'b000;
    reset = 1'b0;
    #1;
    check_eq("post_rst_idle", 32'(cacc0), 32'd1);
    check_eq("post_rst_dacc", 32'(dacc0), 32'd0);
    tick();

    // Single write then read.
    wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    wr_burst(32'h10, 1, 3'b000, 2'b01, "wr1");
    rexp[0] = 32'hDEADBEEF; rresp[0] = 2'b01;
    rd_burst(32'h10, 1, 3'b000, 1'b0, "rd1");
    // MBurstLength of zero behaves as one beat.
    rd_burst(32'h10, 0, 3'b000, 1'b0, "rd_len0");

    // INCR burst, read back with alternating stalls.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); wbe[i] = 4'hF; rexp[i] = 32'(i + 1); rresp[i] = 2'b01;
    end
    wr_burst(32'h20, 4, 3'b000, 2'b01, "wr_incr");
    rd_burst(32'h20, 4, 3'b000, 1'b1, "rd_incr");

    // Byte enables with a STRM burst onto a pre-filled word.
    wd[0] = 32'hFFFFFFFF; wbe[0] = 4'hF;
    wr_burst(32'h40, 1, 3'b000, 2'b01, "wr_fill");
    wd[0] = 32'h0A; wd[1] = 32'h0B; wd[2] = 32'h0C;
    wbe[0] = 4'h0; wbe[1] = 4'h0; wbe[2] = 4'h1;
    wr_burst(32'h40, 3, 3'b101, 2'b01, "wr_strm");
    rexp[0] = 32'hFFFFFF0C; rresp[0] = 2'b01;
    rd_burst(32'h40, 1, 3'b000, 1'b0, "rd_strm");

    // Read at word index MEM_DEPTH is out of range.
    rexp[0] = 32'h0; rresp[0] = 2'b11;
    rd_burst(32'h400, 1, 3'b000, 1'b0, "rd_oor");

    // Unsupported command gives one held ERR beat.
    MCmd = 3'b011;
    #1;
    tick();
    MCmd = 3'b000;
    #1;
    check_eq("errcmd_resp", 32'(resp0), 32'd3);
    check_eq("errcmd_data", sdata0, 32'd0);
    check_eq("errcmd_last", 32'(last0), 32'd1);
    check_eq("errcmd_nocmd", 32'(cacc0), 32'd0);
    tick();
    check_eq("errcmd_held", 32'(resp0), 32'd3);
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
    #1;
    check_eq("errcmd_done", 32'(resp0), 32'd0);
    check_eq("errcmd_idle", 32'(cacc0), 32'd1);

    // Two beats from the last valid word: first lands, second runs off the end.
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wbe[0] = 4'hF; wbe[1] = 4'hF;
    wr_burst(32'h3FC, 2, 3'b000, 2'b11, "wr_edge");
    rexp[0] = 32'h11111111; rresp[0] = 2'b01;
    rd_burst(32'h3FC, 1, 3'b000, 1'b0, "rd_edge");

    // Reset during beat 2 of a 4-beat read.
    MCmd = 3'b010; MAddr = 32'h20; MBurstLength = 10'd4; MBurstSeq = 3'b000;
    #1;
    tick();
    MCmd = 3'b000; MRespAccept = 1'b1;
    #1;
    check_eq("mid_b1_data", sdata0, 32'd1);
    tick();
    check_eq("mid_b2_data", sdata0, 32'd2);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_resp", 32'(resp0), 32'd0);
    check_eq("mid_rst_data", sdata0, 32'd0);
    tick();
    reset = 1'b0; MRespAccept = 1'b0;
    #1;
    check_eq("mid_after_resp", 32'(resp0), 32'd0);
    check_eq("mid_after_idle", 32'(cacc0), 32'd1);
    tick();
    rexp[0] = 32'd2; rresp[0] = 2'b01;
    rd_burst(32'h24, 1, 3'b000, 1'b0, "rd_retained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
